single_port_ram: RTL and testbench
==================================

Name: single_port_ram

Overview:
- 64 x 8 single-port synchronous RAM with one shared address bus and one read/write-enable control.
- Writes and reads share the port: RWE=1 writes, RWE=0 reads. Read data is registered.
- General-purpose scratch storage block, instantiated directly by datapath logic.

Parameters:
- DATA_WIDTH, 8, width of each word and of data_in/data_out.
- ADDR_WIDTH, 6, address width.
- DEPTH, 64, number of words; always 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  write data, sampled on rising clk when RWE=1.
- addr  input  ADDR_WIDTH  word address for both read and write.
- RWE  input  1  read/write enable: 1 = write cycle, 0 = read cycle.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset:
  - rst_n low asynchronously forces data_out to 0 and clears every memory word to 0.
  - Reset is held while rst_n is low. Normal operation resumes on the first rising clk after rst_n goes high.
  - Reset asserted mid-operation aborts any write on that edge; the addressed word ends at 0.
- Write (RWE=1 at rising clk): mem[addr] <= data_in. data_out holds its previous value (no write-through).
- Read (RWE=0 at rising clk): data_out <= mem[addr]. Read latency is 1 cycle, so data_out is valid after the same edge that sampled addr.
- Read-after-write:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data after edge N+1.
  - No hazard stall exists; there is no old/new ambiguity because one port performs one operation per cycle.
- Address range:
  - The full 0..DEPTH-1 range is valid.
  - There is no out-of-range case with default parameters.
  - For non-power-of-two use, DEPTH is constrained to 2**ADDR_WIDTH.
- data_out changes only on a read edge or on reset. It is stable between edges and during write cycles.
- X/Z on RWE or addr: no defined behaviour is required. Verification must not drive them.
- No handshake, no busy flag. A new operation is accepted every cycle.

Decomposition:
- Shared package ram_pkg:
  - default DATA_WIDTH / ADDR_WIDTH localparams.
  - derived DEPTH.
- Optional single sub-module ram_storage_array: reset-clearable register array with write port and registered read port.
- The top level is a thin wrapper mapping RWE to write-enable and read-enable (~RWE).

Test Plan:
- Reset then read addr 0, 1, 63 with RWE=0 -> data_out = 8'h00 after each read edge; data_out = 0 during reset.
- Write 8'h01@0, 8'h02@1, 8'h03@2 on consecutive edges (RWE=1) -> data_out unchanged (0) throughout the writes.
- Read 0, 1, 2 on consecutive edges (RWE=0) -> data_out = 8'h01, 8'h02, 8'h03, each one edge after its address.
- Overwrite 8'h04@1, then read addr 1 on the next edge -> data_out = 8'h04; addr 0 and addr 2 still read 8'h01 and 8'h03.
- Boundary: write 8'hA5@63 and 8'h5A@0, read 63 then 0 -> 8'hA5 then 8'h5A (no aliasing).
- Reset asserted between clock edges after the writes -> data_out goes to 0 immediately; a subsequent read of addr 1 returns 8'h00.

Source files
------------

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared sizing constants for the single-port scratch RAM.
//   DATA_WIDTH : width of each stored word
//   ADDR_WIDTH : width of the word address
//   DEPTH      : number of words, always 2**ADDR_WIDTH
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

endpackage

// File: rtl/ram_storage_array.sv
// ---------------------------------------------------------------------------
// ram_storage_array
// Reset-clearable register array with one write port and one registered read
// port, both addressed by the same address bus.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears every word and rdata_o
//   we_i     : write enable, stores wdata_i at addr_i
//   re_i     : read enable, loads rdata_o from addr_i
//   addr_i   : word address shared by read and write
//   wdata_i  : write data
//   rdata_o  : registered read data, holds its value unless a read occurs
// ---------------------------------------------------------------------------
module ram_storage_array
  import ram_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int AW    = ADDR_WIDTH,
  parameter int WORDS = 2 ** AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Next read-data value: only a read cycle moves the output register, so a
  // write cycle leaves the previously read word visible (no write-through).
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  // Storage and output register. Reset clears the whole array, which also
  // discards any write that coincides with a reset edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/single_port_ram.sv
// ---------------------------------------------------------------------------
// single_port_ram
// 64 x 8 single-port synchronous RAM. One operation per clock: RWE=1 writes
// data_in to addr, RWE=0 reads addr into the registered data_out.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears memory and data_out
//   data_in  : write data, sampled when RWE=1
//   addr     : word address for both reads and writes
//   RWE      : 1 = write cycle, 0 = read cycle
//   data_out : registered read data, one cycle latency
// ---------------------------------------------------------------------------
module single_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  RWE,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic writeEn;
  logic readEn;

  // The single control line selects exactly one of the two port operations.
  assign writeEn = RWE;
  assign readEn  = ~RWE;

  ram_storage_array #(
    .DW    (DATA_WIDTH),
    .AW    (ADDR_WIDTH),
    .WORDS (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (writeEn),
    .re_i    (readEn),
    .addr_i  (addr),
    .wdata_i (data_in),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_single_port_ram.sv
// ---------------------------------------------------------------------------
// tb_single_port_ram
// Self-checking bench for single_port_ram: directed scenarios followed by
// random read/write traffic, compared against a plain array model.
// ---------------------------------------------------------------------------
module tb_single_port_ram;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic [5:0] addr;
  logic       RWE;
  logic [7:0] data_out;

  logic [7:0] refMem [64];
  logic [7:0] refOut;

  int checkCount;
  int passCount;

  single_port_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .addr     (addr),
    .RWE      (RWE),
    .data_out (data_out)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against any hang so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Model of the whole memory being wiped by reset.
  task automatic clearModel();
    for (int i = 0; i < 64; i++) refMem[i] = 8'h00;
    refOut = 8'h00;
  endtask

  // One port operation: drive on the falling edge, let the rising edge act,
  // update the model, then compare shortly after the edge.
  task automatic applyStimulus(input logic rwe, input logic [5:0] a,
                               input logic [7:0] d, input string tag);
    @(negedge clk);
    RWE     = rwe;
    addr    = a;
    data_in = d;
    @(posedge clk);
    if (rwe) refMem[a] = d;
    else     refOut    = refMem[a];
    #1;
    checkOutput(tag, data_out, refOut);
  endtask

  // Releases reset on a falling edge with a harmless read of address 0
  // queued, which after a reset returns zero.
  task automatic releaseReset();
    RWE     = 1'b0;
    addr    = 6'd0;
    data_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    refOut = refMem[0];
    #1;
    checkOutput("post_release", data_out, refOut);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    RWE        = 1'b0;
    addr       = 6'd0;
    data_in    = 8'h00;
    clearModel();

    // Power-on reset, output must be zero while held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_reset", data_out, 8'h00);
    releaseReset();

    // Reads of a freshly cleared memory.
    applyStimulus(1'b0, 6'd0,  8'h00, "rst_rd0");
    applyStimulus(1'b0, 6'd1,  8'h00, "rst_rd1");
    applyStimulus(1'b0, 6'd63, 8'h00, "rst_rd63");

    // Writes leave data_out untouched.
    applyStimulus(1'b1, 6'd0, 8'h01, "wr0_hold");
    applyStimulus(1'b1, 6'd1, 8'h02, "wr1_hold");
    applyStimulus(1'b1, 6'd2, 8'h03, "wr2_hold");
    checkOutput("wr_hold_const", data_out, 8'h00);

    // Read back in order.
    applyStimulus(1'b0, 6'd0, 8'h00, "rd0");
    checkOutput("rd0_const", data_out, 8'h01);
    applyStimulus(1'b0, 6'd1, 8'h00, "rd1");
    checkOutput("rd1_const", data_out, 8'h02);
    applyStimulus(1'b0, 6'd2, 8'h00, "rd2");
    checkOutput("rd2_const", data_out, 8'h03);

    // Overwrite then immediate read-after-write; neighbours untouched.
    applyStimulus(1'b1, 6'd1, 8'h04, "ovr_wr1");
    applyStimulus(1'b0, 6'd1, 8'h00, "raw_rd1");
    checkOutput("raw_const", data_out, 8'h04);
    applyStimulus(1'b0, 6'd0, 8'h00, "nb_rd0");
    checkOutput("nb0_const", data_out, 8'h01);
    applyStimulus(1'b0, 6'd2, 8'h00, "nb_rd2");
    checkOutput("nb2_const", data_out, 8'h03);

    // Address extremes do not alias.
    applyStimulus(1'b1, 6'd63, 8'hA5, "wr63");
    applyStimulus(1'b1, 6'd0,  8'h5A, "wr0b");
    applyStimulus(1'b0, 6'd63, 8'h00, "rd63");
    checkOutput("rd63_const", data_out, 8'hA5);
    applyStimulus(1'b0, 6'd0,  8'h00, "rd0b");
    checkOutput("rd0b_const", data_out, 8'h5A);

    // Asynchronous reset between edges clears output at once and memory.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", data_out, 8'h00);
    clearModel();
    repeat (2) @(posedge clk);
    releaseReset();
    applyStimulus(1'b0, 6'd1, 8'h00, "after_rst_rd1");
    checkOutput("after_rst_const", data_out, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                    8'($urandom), "rand");
    end

    // Full sweep so every word is compared.
    for (int a = 0; a < 64; a++) begin
      applyStimulus(1'b0, 6'(a), 8'h00, "sweep");
    end

    // Reset overlapping a write edge aborts that write.
    applyStimulus(1'b1, 6'd5, 8'h77, "pre_abort_wr");
    @(negedge clk);
    RWE     = 1'b1;
    addr    = 6'd5;
    data_in = 8'hFF;
    #2;
    rst_n = 1'b0;
    clearModel();
    @(posedge clk);
    #1;
    checkOutput("abort_edge", data_out, 8'h00);
    releaseReset();
    applyStimulus(1'b0, 6'd5, 8'h00, "abort_rd5");
    checkOutput("abort_const", data_out, 8'h00);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
